// File: rtl/rom_download_router.sv
// rtl/rom_download_router.sv - ioctl ROM byte packer and toggle-handshake multi-port sdram write router
// Optional feature: define ROM_CHECKSUM_EN to add the 16-bit byte-sum output checksum.
module rom_download_router #(
    parameter int                NPORTS     = 2,
    parameter int                AW         = 23,
    parameter logic [7:0]        ROM_INDEX  = 8'd0,
    parameter logic [NPORTS-1:0] PORT_MASK  = 2'b11,
    parameter int                RESET_HOLD = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              user_reset,
    output logic [NPORTS-1:0] port_req,
    input  logic [NPORTS-1:0] port_ack,
    output logic [AW-1:0]     port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    output logic              rom_init,
    output logic              rom_loaded,
    output logic              core_reset,
`ifdef ROM_CHECKSUM_EN
    output logic              overflow,
    output logic [15:0]       checksum
`else
    output logic              overflow
`endif
);

    localparam int CW = $clog2(RESET_HOLD + 1);

    typedef enum logic {
        WR_IDLE,
        WR_WAIT_ACK
    } wr_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_HOLD,
        ST_LOADED
    } ld_state_t;

    wr_state_t wr_state, wr_state_nxt;
    ld_state_t ld_state, ld_state_nxt;

    logic          wr_q;
    logic          rom_init_q;
    logic          evt_q;
    logic          end_q;
    logic [24:0]   evt_addr;
    logic [7:0]    evt_data;
    logic          init_rise;

    logic          pend, pend_nxt;
    logic          take_new;
    logic [24:0]   held_addr;
    logic [7:0]    held_data;

    logic          word_vld;
    logic [AW-1:0] word_a;
    logic [1:0]    word_ds;
    logic [15:0]   word_d;

    logic          skid_vld;
    logic [AW-1:0] skid_a;
    logic [1:0]    skid_ds;
    logic [15:0]   skid_d;
    logic          skid_load, skid_clr;

    logic          issue;
    logic          drop;
    logic [AW-1:0] iss_a;
    logic [1:0]    iss_ds;
    logic [15:0]   iss_d;
    logic          ack_done;

    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic          loaded_set;

    assign rom_init  = ioctl_download && (ioctl_index == ROM_INDEX);
    assign init_rise = rom_init && !rom_init_q;
    assign ack_done  = ((port_ack ^ port_req) & PORT_MASK) == '0;

    // Byte pairing: an even byte waits for its odd partner; anything else flushes it alone.
    always_comb begin
        word_vld = 1'b0;
        word_a   = held_addr[AW:1];
        word_ds  = held_addr[0] ? 2'b10 : 2'b01;
        word_d   = {held_data, held_data};
        pend_nxt = pend;
        take_new = 1'b0;
        if (evt_q) begin
            if (pend && !held_addr[0] && (evt_addr == held_addr + 25'd1)) begin
                word_vld = 1'b1;
                word_ds  = 2'b11;
                word_d   = {evt_data, held_data};
                pend_nxt = 1'b0;
            end else if (pend) begin
                word_vld = 1'b1;
                take_new = 1'b1;
            end else if (evt_addr[0]) begin
                word_vld = 1'b1;
                word_a   = evt_addr[AW:1];
                word_ds  = 2'b10;
                word_d   = {evt_data, evt_data};
            end else begin
                pend_nxt = 1'b1;
                take_new = 1'b1;
            end
        end else if (end_q && pend) begin
            word_vld = 1'b1;
            pend_nxt = 1'b0;
        end
    end

    // Write issue: the skid entry always goes out before a freshly completed word.
    always_comb begin
        wr_state_nxt = wr_state;
        issue        = 1'b0;
        drop         = 1'b0;
        skid_load    = 1'b0;
        skid_clr     = 1'b0;
        iss_a        = word_a;
        iss_ds       = word_ds;
        iss_d        = word_d;
        case (wr_state)
            WR_IDLE: begin
                if (skid_vld) begin
                    issue     = 1'b1;
                    iss_a     = skid_a;
                    iss_ds    = skid_ds;
                    iss_d     = skid_d;
                    skid_clr  = 1'b1;
                    skid_load = word_vld;
                end else if (word_vld) begin
                    issue = 1'b1;
                end
                if (issue) begin
                    wr_state_nxt = WR_WAIT_ACK;
                end
            end
            WR_WAIT_ACK: begin
                if (ack_done) begin
                    wr_state_nxt = WR_IDLE;
                end
                if (word_vld) begin
                    if (!skid_vld) begin
                        skid_load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        ld_state_nxt = ld_state;
        hold_cnt_nxt = hold_cnt;
        loaded_set   = 1'b0;
        case (ld_state)
            ST_IDLE: begin
                if (end_q) begin
                    ld_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_state == WR_IDLE && !skid_vld && !word_vld) begin
                    ld_state_nxt = ST_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == CW'(RESET_HOLD - 1)) begin
                    ld_state_nxt = ST_LOADED;
                    loaded_set   = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            ST_LOADED: begin
                if (init_rise) begin
                    ld_state_nxt = ST_IDLE;
                end
            end
            default: ld_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q       <= 1'b0;
            rom_init_q <= 1'b0;
            evt_q      <= 1'b0;
            end_q      <= 1'b0;
            evt_addr   <= '0;
            evt_data   <= '0;
            pend       <= 1'b0;
            held_addr  <= '0;
            held_data  <= '0;
        end else begin
            wr_q       <= ioctl_wr;
            rom_init_q <= rom_init;
            evt_q      <= ioctl_wr && !wr_q && rom_init;
            end_q      <= rom_init_q && !rom_init;
            if (ioctl_wr && !wr_q) begin
                evt_addr <= ioctl_addr;
                evt_data <= ioctl_dout;
            end
            pend <= pend_nxt;
            if (take_new) begin
                held_addr <= evt_addr;
                held_data <= evt_data;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= WR_IDLE;
            port_req <= '0;
            port_a   <= '0;
            port_ds  <= '0;
            port_d   <= '0;
            skid_vld <= 1'b0;
            skid_a   <= '0;
            skid_ds  <= '0;
            skid_d   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            if (issue) begin
                port_req <= port_req ^ PORT_MASK;
                port_a   <= iss_a;
                port_ds  <= iss_ds;
                port_d   <= iss_d;
            end
            if (skid_load) begin
                skid_vld <= 1'b1;
                skid_a   <= word_a;
                skid_ds  <= word_ds;
                skid_d   <= word_d;
            end else if (skid_clr) begin
                skid_vld <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ld_state   <= ST_IDLE;
            hold_cnt   <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            ld_state   <= ld_state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            if (loaded_set) begin
                rom_loaded <= 1'b1;
            end
            core_reset <= user_reset || !rom_loaded || (ld_state == ST_HOLD);
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_add;

    assign sum_add = {8'd0, (word_ds[0] ? word_d[7:0]  : 8'd0)}
                   + {8'd0, (word_ds[1] ? word_d[15:8] : 8'd0)};

    // Bytes count once their word is accepted, so dropped words never reach the sum.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (init_rise) begin
            checksum <= '0;
        end else if (word_vld && !drop && ld_state != ST_LOADED) begin
            checksum <= checksum + sum_add;
        end
    end
`endif

endmodule

// File: tb/tb_rom_download_router.sv
// tb/tb_rom_download_router.sv - randomized self-checking bench for rom_download_router
module tb_rom_download_router;

    localparam int AW         = 23;
    localparam int RESET_HOLD = 16;

    typedef struct packed {
        logic [24:0] a;
        logic [7:0]  d;
    } byte_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        user_reset = 1'b0;

    logic [1:0]    port_req;
    logic [1:0]    port_ack = 2'b00;
    logic [AW-1:0] port_a;
    logic [1:0]    port_ds;
    logic [15:0]   port_d;
    logic          rom_init, rom_loaded, core_reset, overflow;

    logic [1:0]    m_req;
    logic [1:0]    m_ack = 2'b10;
    logic [AW-1:0] m_a;
    logic [1:0]    m_ds;
    logic [15:0]   m_d;
    logic          m_rom_init, m_rom_loaded, m_core_reset, m_overflow;

    int          checks = 0;
    int          failures = 0;
    int          ack_lat = 3;
    int          tog0 = 0, tog1 = 0, m_tog0 = 0;
    bit          m_req1_seen = 1'b0;
    byte_t       bytes[$];
    logic [40:0] exp_q[$], got_q[$], m_got_q[$];

    rom_download_router #(.NPORTS(2), .AW(AW), .ROM_INDEX(8'd0), .PORT_MASK(2'b11),
                          .RESET_HOLD(RESET_HOLD)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset), .port_req(port_req),
        .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
        .rom_init(rom_init), .rom_loaded(rom_loaded), .core_reset(core_reset),
        .overflow(overflow)
    );

    rom_download_router #(.NPORTS(2), .AW(AW), .ROM_INDEX(8'd0), .PORT_MASK(2'b01),
                          .RESET_HOLD(RESET_HOLD)) u_dut_mask (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset), .port_req(m_req),
        .port_ack(m_ack), .port_a(m_a), .port_ds(m_ds), .port_d(m_d),
        .rom_init(m_rom_init), .rom_loaded(m_rom_loaded), .core_reset(m_core_reset),
        .overflow(m_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [40:0] single_wr(input byte_t b);
        return {b.a[AW:1], (b.a[0] ? 2'b10 : 2'b01), b.d, b.d};
    endfunction

    // Reference: walk the byte list, pairing even/odd neighbours, flushing everything else alone.
    function automatic void build_expected();
        bit    pend;
        byte_t h;
        pend = 1'b0;
        h    = '0;
        exp_q.delete();
        foreach (bytes[i]) begin
            if (pend && !h.a[0] && bytes[i].a == h.a + 25'd1) begin
                exp_q.push_back({h.a[AW:1], 2'b11, bytes[i].d, h.d});
                pend = 1'b0;
            end else begin
                if (pend) exp_q.push_back(single_wr(h));
                if (!pend && bytes[i].a[0]) begin
                    exp_q.push_back(single_wr(bytes[i]));
                end else begin
                    h    = bytes[i];
                    pend = 1'b1;
                end
            end
        end
        if (pend) exp_q.push_back(single_wr(h));
    endfunction

    task automatic compare_writes(input string tag, input bit with_mask);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
        if (with_mask) begin
            check({tag, "_mcount"}, 64'(m_got_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < m_got_q.size(); i++)
                check({tag, "_mwr"}, 64'(m_got_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic begin_dl(input logic [7:0] idx);
        bytes.delete();
        got_q.delete();
        m_got_q.delete();
        tog0 = 0;
        tog1 = 0;
        m_tog0 = 0;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        tick(gap);
        bytes.push_back({a, d});
    endtask

    task automatic wait_reload(input string tag, input int bound);
        int n;
        n = 0;
        while (!core_reset && n < bound) begin tick(1); n++; end
        check({tag, "_reset_seen"}, 64'(core_reset), 64'(1));
        n = 0;
        while ((core_reset || !rom_loaded) && n < bound) begin tick(1); n++; end
        check({tag, "_reload_done"}, 64'(!core_reset && rom_loaded), 64'(1));
        tick(4);
    endtask

    // sdram side: each port answers a req toggle after ack_lat cycles; mask DUT ack[1] tied high.
    initial begin
        int c, mc;
        c = 0;
        mc = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                port_ack = 2'b00;
                m_ack[0] = 1'b0;
                c = 0;
                mc = 0;
            end else begin
                if (port_req != port_ack) begin
                    c++;
                    if (c >= ack_lat) begin port_ack = port_req; c = 0; end
                end else c = 0;
                if (m_req[0] != m_ack[0]) begin
                    mc++;
                    if (mc >= 3) begin m_ack[0] = m_req[0]; mc = 0; end
                end else mc = 0;
            end
        end
    end

    initial begin
        logic [1:0]  p, mp;
        logic        busy, mbusy;
        logic [40:0] rec, mrec;
        p = 2'b00; mp = 2'b00; busy = 1'b0; mbusy = 1'b0; rec = '0; mrec = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                p = 2'b00; mp = 2'b00; busy = 1'b0; mbusy = 1'b0;
            end else begin
                if (port_req[0] != p[0]) begin
                    rec = {port_a, port_ds, port_d};
                    got_q.push_back(rec);
                    tog0++;
                    busy = 1'b1;
                end
                if (port_req[1] != p[1]) tog1++;
                if (busy && port_ack == port_req) begin
                    check("hold_stable", 64'({port_a, port_ds, port_d}), 64'(rec));
                    busy = 1'b0;
                end
                if (m_req[0] != mp[0]) begin
                    mrec = {m_a, m_ds, m_d};
                    m_got_q.push_back(mrec);
                    m_tog0++;
                    mbusy = 1'b1;
                end
                if (m_req[1]) m_req1_seen = 1'b1;
                if (mbusy && m_ack[0] == m_req[0]) begin
                    check("mhold_stable", 64'({m_a, m_ds, m_d}), 64'(mrec));
                    mbusy = 1'b0;
                end
                p = port_req;
                mp = m_req;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, start, cnt;
        reset_n = 1'b0;
        tick(3);
        check("rst_req", 64'(port_req), 64'(0));
        check("rst_a", 64'(port_a), 64'(0));
        check("rst_ds", 64'(port_ds), 64'(0));
        check("rst_d", 64'(port_d), 64'(0));
        check("rst_loaded", 64'(rom_loaded), 64'(0));
        check("rst_core_reset", 64'(core_reset), 64'(1));
        check("rst_overflow", 64'(overflow), 64'(0));
        reset_n = 1'b1;
        tick(2);

        // Non-ROM index is ignored entirely.
        begin_dl(8'd1);
        check("idx1_rom_init", 64'(rom_init), 64'(0));
        send_byte(25'd0, 8'h12, 3);
        send_byte(25'd1, 8'h34, 3);
        ioctl_download = 1'b0;
        tick(40);
        check("idx1_toggles", 64'(tog0 + tog1 + m_tog0), 64'(0));
        check("idx1_loaded", 64'(rom_loaded), 64'(0));
        check("idx1_core_reset", 64'(core_reset), 64'(1));

        // First ROM download: one paired word on both ports.
        begin_dl(8'd0);
        check("t1_rom_init", 64'({rom_init, m_rom_init}), 64'(2'b11));
        send_byte(25'd0, 8'hAA, 3);
        send_byte(25'd1, 8'h55, 10);
        tick(10);
        ioctl_download = 1'b0;
        n = 0;
        while (!rom_loaded && n < 200) begin tick(1); n++; end
        check("t1_hold_window", 64'(n >= RESET_HOLD && n <= RESET_HOLD + 8), 64'(1));
        build_expected();
        compare_writes("t1", 1'b1);
        check("t1_word", 64'(got_q.size() > 0 ? got_q[0] : '0), 64'({23'd0, 2'b11, 16'h55AA}));
        check("t1_toggles", 64'({tog0[7:0], tog1[7:0], m_tog0[7:0]}), 64'(24'h010101));
        check("t1_req", 64'(port_req), 64'(2'b11));
        check("t1_mask_loaded", 64'(m_rom_loaded), 64'(1));
        tick(2);
        check("t1_core_run", 64'({core_reset, m_core_reset}), 64'(0));

        user_reset = 1'b1;
        tick(2);
        check("user_reset_hi", 64'(core_reset), 64'(1));
        user_reset = 1'b0;
        tick(2);
        check("user_reset_lo", 64'(core_reset), 64'(0));

        // Restart in LOADED with a trailing odd byte.
        begin_dl(8'd0);
        send_byte(25'd0, 8'h11, 5);
        send_byte(25'd1, 8'h22, 5);
        send_byte(25'd2, 8'h33, 5);
        tick(10);
        ioctl_download = 1'b0;
        wait_reload("t2", 200);
        build_expected();
        compare_writes("t2", 1'b1);
        check("t2_w0", 64'(got_q.size() > 0 ? got_q[0] : '0), 64'({23'd0, 2'b11, 16'h2211}));
        check("t2_w1", 64'(got_q.size() > 1 ? got_q[1] : '0), 64'({23'd1, 2'b01, 16'h3333}));

        // Random runs with arbitrary start addresses and an optional jump.
        for (int it = 0; it < 4; it++) begin
            begin_dl(8'd0);
            for (int seg = 0; seg < 2; seg++) begin
                start = $urandom_range(0, 60);
                cnt = $urandom_range(2, 9);
                for (int k = 0; k < cnt; k++)
                    send_byte(25'(start + k), 8'($urandom_range(0, 255)), 5);
            end
            tick(10);
            ioctl_download = 1'b0;
            wait_reload("rnd", 300);
            build_expected();
            compare_writes("rnd", 1'b1);
            check("rnd_no_overflow", 64'({overflow, m_overflow}), 64'(0));
        end

        // Ack held off: first word issued, second skidded, third dropped.
        ack_lat = 40;
        begin_dl(8'd0);
        for (int k = 0; k < 6; k++)
            send_byte(25'(k), 8'($urandom_range(0, 255)), 3);
        tick(5);
        ioctl_download = 1'b0;
        wait_reload("ovf", 400);
        build_expected();
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        compare_writes("ovf", 1'b0);
        check("ovf_flag", 64'(overflow), 64'(1));
        check("ovf_mask_flag", 64'(m_overflow), 64'(0));

        // Reset while a write is outstanding.
        begin_dl(8'd0);
        send_byte(25'd0, 8'h5A, 3);
        send_byte(25'd1, 8'hA5, 3);
        tick(3);
        check("rst_pre_wait", 64'(port_req ^ port_ack), 64'(2'b11));
        reset_n = 1'b0;
        tick(1);
        check("rst_mid_req", 64'(port_req), 64'(0));
        check("rst_mid_core_reset", 64'(core_reset), 64'(1));
        check("rst_mid_overflow", 64'(overflow), 64'(0));
        check("rst_mid_loaded", 64'(rom_loaded), 64'(0));
        ioctl_download = 1'b0;
        ack_lat = 3;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("rst_after_ack", 64'({port_req, port_ack}), 64'(0));
        check("mask_req1", 64'(m_req1_seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_download_router.md
Name: rom_download_router

Overview:
- Generalised ROM download controller between data_io (ioctl_*) and the multi-port sdram controller.
- Captures download bytes for one ioctl_index and packs byte pairs into 16-bit words.
- Issues toggle-style req/ack writes to NPORTS sdram ports at once, with a 1-deep skid buffer and an end-of-download flush of a trailing odd byte.
- Generates rom_loaded and a stretched core reset. It replaces the ad-hoc edge/toggle logic in each core top.

Parameters:
- NPORTS, 2, number of sdram write ports driven in parallel (1..4).
- AW, 23, word address width presented to sdram ports.
- ROM_INDEX, 0, ioctl_index value that selects ROM download.
- PORT_MASK, 2'b11, per-port enable; disabled ports never toggle req (width NPORTS).
- RESET_HOLD, 16, clk_sys cycles core_reset stays high after the download ends (>=1).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  data_io download active.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  byte strobe (level; rising edge is the event).
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- user_reset  in  1  OR of status[0] and buttons[1].
- port_req  out  NPORTS  toggle request per port.
- port_ack  in  NPORTS  toggle acknowledge per port.
- port_a  out  AW  word address (byte addr >> 1).
- port_ds  out  2  byte strobes {hi,lo}.
- port_d  out  16  write data.
- rom_init  out  1  ioctl_download && ioctl_index==ROM_INDEX.
- rom_loaded  out  1  sticky: first download completed.
- core_reset  out  1  reset to game core.
- overflow  out  1  sticky: byte lost because the buffer was full.

Behaviour:
- Reset: port_req=0, port_a=0, port_ds=0, port_d=0, rom_loaded=0, core_reset=1, overflow=0, FSM=IDLE, skid and pack registers empty. rom_init is combinational.
- Event: ioctl_wr rising edge, registered one cycle, while rom_init=1. Edges with a non-matching index are ignored.
- Packing: even byte address is held as lo byte with pend=1. Next event:
  - address == held+1: forms {hi,lo}, ds=2'b11, one write.
  - any other address: held byte flushed as a single write (ds=2'b01, data {b,b}), new byte becomes the pending byte.
  - Odd-address byte with no pending byte: single write, ds=2'b10, data {b,b}.
- Write issue: in IDLE with a ready word, latch a/ds/d and toggle port_req[i] for each PORT_MASK[i] bit. Go to WAIT_ACK.
- WAIT_ACK: stay until port_ack==port_req on all masked ports, then IDLE. Issue latency from completing event to req toggle: 1 cycle when IDLE.
- Skid: a word completed during WAIT_ACK goes into a 1-entry buffer and is issued the cycle after the return to IDLE. A further word while the buffer is full is dropped and sets overflow.
- Address/data outputs stay stable from the req toggle until all acks return.
- End of download (ioctl_download falling edge, registered): any pending byte is flushed as a single write. FSM goes to DRAIN, then to HOLD once IDLE with the buffer empty. HOLD counts RESET_HOLD cycles, then sets rom_loaded=1 and goes to LOADED.
- core_reset = user_reset | ~rom_loaded | (state==HOLD), registered.
- Download restart in LOADED: rom_loaded stays 1; capture resumes; core_reset is reasserted through a new DRAIN/HOLD.
- reset_n mid-transfer: everything returns to reset values immediately; port_req returns to 0. The sdram side must also be reset so ack matches.

Optional Feature:
- Macro ROM_CHECKSUM_EN.
- Defined: adds output checksum [15:0], the modular 16-bit sum of every accepted byte (dropped bytes excluded), cleared on the rising edge of rom_init and frozen in LOADED.
- Undefined: port absent, no adder logic.

Test Plan:
- Bytes 0xAA@0, 0x55@1 with ack returned 3 cycles after req -> one write a=0, ds=11, d=0x55AA; both port_req toggle 0->1 once; rom_loaded=1 exactly RESET_HOLD+drain cycles after download falls.
- 3 bytes 0x11,0x22,0x33 @0..2, then download ends -> writes {0x2211,ds=11,a=0} and {0x3333,ds=01,a=1}.
- ack held off 40 cycles while 6 bytes arrive -> first word issued, second buffered, third dropped; overflow=1.
- ioctl_index=1 download -> no req toggles, rom_loaded stays 0, core_reset=1.
- PORT_MASK=2'b01 -> port_req[1] stays 0; completion waits only on ack[0].
- reset_n low during WAIT_ACK -> next cycle port_req=0, core_reset=1, overflow=0, rom_loaded=0.
